// File: rtl/gray_sync_decode.sv
// Gray-code resynchroniser with registered binary decode and step detection.
// Optional GRAY_SYNC_ERR_EN enables the sticky step_err flag and clr_err.
module gray_sync_decode #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             inc,
  output logic             dec,
  output logic             step_err
);

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] PRIME_MAX = CW'(SYNC_STAGES + 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff;
  logic             primed;
  logic             is_inc;
  logic             is_dec;

  function automatic logic [WIDTH-1:0] gray2bin(
    input logic [WIDTH-1:0] g
  );
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain; no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Decode, step distance and priming window.
  always_comb begin
    bin_d  = gray2bin(sync_q[SYNC_STAGES-1]);
    diff   = bin_d - bin_q;
    primed = (cnt_q == PRIME_MAX);
    is_inc = (diff == ONE);
    is_dec = (diff == ONES) && !is_inc;
    inc_d  = primed && is_inc;
    dec_d  = primed && is_dec;
    cnt_d  = primed ? cnt_q : cnt_q + CW'(1);
  end

  // Output and priming-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      inc_q <= inc_d;
      dec_q <= dec_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef GRAY_SYNC_ERR_EN
  logic err_q, err_d;

  // Sticky error: a new illegal step beats a same-cycle clear.
  always_comb begin
    err_d = err_q;
    if (clr_err) begin
      err_d = 1'b0;
    end
    if (primed && (diff != '0) && !is_inc && !is_dec) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign step_err = err_q;
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign step_err   = 1'b0;
`endif

  assign bin_out = bin_q;
  assign inc     = inc_q;
  assign dec     = dec_q;

endmodule

// File: tb/tb_gray_sync_decode.sv
// Directed, table-driven bench for gray_sync_decode (WIDTH=4, N=2).
// Error expectations follow GRAY_SYNC_ERR_EN.
module tb_gray_sync_decode;

`ifdef GRAY_SYNC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       clr_err;
  logic [3:0] bin_out;
  logic       inc;
  logic       dec;
  logic       step_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] g;
    logic       c;
    logic [3:0] b;
    logic       i;
    logic       d;
    logic       e;
  } vec_t;

  vec_t vecs[$];

  gray_sync_decode #(
    .WIDTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .gray_in(gray_in),
    .clr_err(clr_err),
    .bin_out(bin_out),
    .inc(inc),
    .dec(dec),
    .step_err(step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] b,
                           input logic i, input logic d, input logic e);
    chk({tag, " bin_out"}, 32'(bin_out), 32'(b));
    chk({tag, " inc"}, 32'(inc), 32'(i));
    chk({tag, " dec"}, 32'(dec), 32'(d));
    chk({tag, " step_err"}, 32'(step_err), 32'(e & ERR_EN));
    chk({tag, " inc&dec"}, 32'(inc & dec), 32'd0);
  endtask

  task automatic cyc(input string tag, input logic [3:0] g,
                     input logic c, input logic [3:0] b,
                     input logic i, input logic d, input logic e);
    gray_in = g;
    clr_err = c;
    @(posedge clk);
    #1;
    check_out(tag, b, i, d, e);
  endtask

  task automatic add(input logic [3:0] g, input logic c,
                     input logic [3:0] b, input logic i,
                     input logic d, input logic e);
    vec_t v;
    v.g = g; v.c = c; v.b = b; v.i = i; v.d = d; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic hold4(input logic [3:0] g, input logic [3:0] oldb,
                       input logic [3:0] newb, input logic i,
                       input logic d, input logic e_new);
    add(g, 0, oldb, 0, 0, 0);
    add(g, 0, oldb, 0, 0, 0);
    add(g, 0, newb, i, d, e_new);
    add(g, 0, newb, 0, 0, e_new);
  endtask

  initial begin
    // Count up 0..3, step back to 2, down through wrap, up through wrap.
    hold4(4'b0001, 4'd0, 4'd1, 1, 0, 0);
    hold4(4'b0011, 4'd1, 4'd2, 1, 0, 0);
    hold4(4'b0010, 4'd2, 4'd3, 1, 0, 0);
    hold4(4'b0011, 4'd3, 4'd2, 0, 1, 0);
    hold4(4'b0001, 4'd2, 4'd1, 0, 1, 0);
    hold4(4'b0000, 4'd1, 4'd0, 0, 1, 0);
    hold4(4'b1000, 4'd0, 4'd15, 0, 1, 0);
    hold4(4'b0000, 4'd15, 4'd0, 1, 0, 0);
    // Illegal jump 0 -> 2, then clear.
    add(4'b0011, 0, 4'd0, 0, 0, 0);
    add(4'b0011, 0, 4'd0, 0, 0, 0);
    add(4'b0011, 0, 4'd2, 0, 0, 1);
    add(4'b0011, 0, 4'd2, 0, 0, 1);
    add(4'b0011, 0, 4'd2, 0, 0, 1);
    add(4'b0011, 1, 4'd2, 0, 0, 0);
    add(4'b0011, 0, 4'd2, 0, 0, 0);
    // Illegal jump 2 -> 0 landing on a clr_err cycle: set wins.
    add(4'b0000, 0, 4'd2, 0, 0, 0);
    add(4'b0000, 0, 4'd2, 0, 0, 0);
    add(4'b0000, 1, 4'd0, 0, 0, 1);
    add(4'b0000, 0, 4'd0, 0, 0, 1);
    add(4'b0000, 0, 4'd0, 0, 0, 1);

    // Reset with 0110 held, primed load to 4.
    rst_n   = 1'b0;
    gray_in = 4'b0110;
    clr_err = 1'b0;
    #12;
    check_out("reset", 4'd0, 0, 0, 0);
    rst_n = 1'b1;
    cyc("prime e1", 4'b0110, 0, 4'd0, 0, 0, 0);
    cyc("prime e2", 4'b0110, 0, 4'd0, 0, 0, 0);
    cyc("prime e3", 4'b0110, 0, 4'd4, 0, 0, 0);
    cyc("prime e4", 4'b0110, 0, 4'd4, 0, 0, 0);

    // Fresh start from gray 0000.
    #2;
    rst_n   = 1'b0;
    gray_in = 4'b0000;
    #2;
    rst_n = 1'b1;
    cyc("zero e1", 4'b0000, 0, 4'd0, 0, 0, 0);
    cyc("zero e2", 4'b0000, 0, 4'd0, 0, 0, 0);
    cyc("zero e3", 4'b0000, 0, 4'd0, 0, 0, 0);

    foreach (vecs[k]) begin
      cyc($sformatf("vec%0d", k), vecs[k].g, vecs[k].c,
          vecs[k].b, vecs[k].i, vecs[k].d, vecs[k].e);
    end

    // Mid-operation async reset while inc is high.
    cyc("mid e1", 4'b0001, 0, 4'd0, 0, 0, 1);
    cyc("mid e2", 4'b0001, 0, 4'd0, 0, 0, 1);
    cyc("mid e3", 4'b0001, 0, 4'd1, 1, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async rst", 4'd0, 0, 0, 0);
    gray_in = 4'b0011;
    #2;
    rst_n = 1'b1;
    cyc("post e1", 4'b0011, 0, 4'd0, 0, 0, 0);
    cyc("post e2", 4'b0011, 0, 4'd0, 0, 0, 0);
    cyc("post e3", 4'b0011, 0, 4'd2, 0, 0, 0);
    cyc("post e4", 4'b0011, 0, 4'd2, 0, 0, 0);
    cyc("post e5", 4'b0010, 0, 4'd2, 0, 0, 0);
    cyc("post e6", 4'b0010, 0, 4'd2, 0, 0, 0);
    cyc("post e7", 4'b0010, 0, 4'd3, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
